// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the native-to-AXI4-lite initiator.
package axi4lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WADDR_DATA = 3'd1,
    ST_WRESP      = 3'd2,
    ST_RADDR      = 3'd3,
    ST_RDATA      = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam logic [2:0]        PROT_DATA  = 3'b000;
  localparam logic [2:0]        PROT_INSN  = 3'b100;
  localparam logic [STRB_W-1:0] WSTRB_NONE = 4'b0000;

endpackage

// File: rtl/axi4lite_watchdog.sv
// Saturating stall counter with a sticky expiry flag; TIMEOUT_CYCLES=0 disables it.
module axi4lite_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit   ENABLE = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Next count and flag: clear wins, otherwise count up to LIMIT and hold.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (ENABLE && (cnt_d == LIMIT)) begin
        expired_d = 1'b1;
      end
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/axi4lite_native_master.sv
// Native valid/ready memory port to AXI4-lite initiator, one transaction in flight.
module axi4lite_native_master
  import axi4lite_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_axi_awvalid,
  input  logic              mem_axi_awready,
  output logic [ADDR_W-1:0] mem_axi_awaddr,
  output logic [2:0]        mem_axi_awprot,
  output logic              mem_axi_wvalid,
  input  logic              mem_axi_wready,
  output logic [DATA_W-1:0] mem_axi_wdata,
  output logic [STRB_W-1:0] mem_axi_wstrb,
  input  logic              mem_axi_bvalid,
  output logic              mem_axi_bready,
  output logic              mem_axi_arvalid,
  input  logic              mem_axi_arready,
  output logic [ADDR_W-1:0] mem_axi_araddr,
  output logic [2:0]        mem_axi_arprot,
  input  logic              mem_axi_rvalid,
  output logic              mem_axi_rready,
  input  logic [DATA_W-1:0] mem_axi_rdata,
  output logic              busy,
  output logic              timeout
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                instr_q, instr_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;
  logic                bready_q, bready_d;
  logic                rready_q, rready_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic                wd_clear, wd_count;

  // Next-state and channel-register logic; every AXI control output is a flop.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    instr_d   = instr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    bready_d  = bready_q;
    rready_d  = rready_q;
    ready_d   = 1'b0;
    rdata_d   = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          if (mem_wstrb != WSTRB_NONE) begin
            state_d   = ST_WADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR_DATA: begin
        // AW and W retire independently; leave once neither is pending.
        if (mem_axi_awready) awvalid_d = 1'b0;
        if (mem_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (mem_axi_bvalid) begin
          bready_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_RADDR: begin
        if (mem_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (mem_axi_rvalid) begin
          rready_d = 1'b0;
          rdata_d  = mem_axi_rdata;
          ready_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and channel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      instr_q   <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      instr_q   <= instr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      rdata_q   <= rdata_d;
      busy_q    <= busy_d;
    end
  end

  // Watchdog restarts on each state change and runs only while waiting on the bus.
  assign wd_clear = (state_d != state_q);
  assign wd_count = (state_q == ST_WADDR_DATA) || (state_q == ST_WRESP) ||
                    (state_q == ST_RADDR) || (state_q == ST_RDATA);

  axi4lite_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .count_en(wd_count),
    .expired (timeout)
  );

  assign mem_ready       = ready_q;
  assign mem_rdata       = rdata_q;
  assign mem_axi_awvalid = awvalid_q;
  assign mem_axi_awaddr  = addr_q;
  assign mem_axi_awprot  = PROT_DATA;
  assign mem_axi_wvalid  = wvalid_q;
  assign mem_axi_wdata   = wdata_q;
  assign mem_axi_wstrb   = wstrb_q;
  assign mem_axi_bready  = bready_q;
  assign mem_axi_arvalid = arvalid_q;
  assign mem_axi_araddr  = addr_q;
  assign mem_axi_arprot  = instr_q ? PROT_INSN : PROT_DATA;
  assign mem_axi_rready  = rready_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_axi4lite_native_master.sv
// Directed and randomised bench for axi4lite_native_master with an AXI4-lite responder model.
module tb_axi4lite_native_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        busy, timeout;

  axi4lite_native_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
    .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
    .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
    .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
    .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Responder knobs, written by the main sequence between transactions.
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

  // Responder memory (word index = addr[5:2]) and bus monitor results.
  logic [31:0] rmem [16] = '{32'hCAFEF00D, 32'h11112222, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, viol = 0, cyc = 0;
  int          aw_t = 0, w_t = 0;
  logic [31:0] aw_cap = 0, wd_cap = 0, ar_cap = 0;
  logic [3:0]  ws_cap = 0;
  logic [2:0]  ap_cap = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] s);
    logic [63:0] x;
    x = s;
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  // Responder: drives ready/valid on the falling edge after a per-channel wait.
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = 0;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      end else begin
        awready = awvalid && (aw_c >= aw_dly);
        if (awvalid && !awready) aw_c++; else if (!awvalid) aw_c = 0;
        wready = wvalid && (w_c >= w_dly);
        if (wvalid && !wready) w_c++; else if (!wvalid) w_c = 0;
        bvalid = bready && (b_c >= b_dly);
        if (bready && !bvalid) b_c++; else if (!bready) b_c = 0;
        arready = arvalid && (ar_c >= ar_dly);
        if (arvalid && !arready) ar_c++; else if (!arvalid) ar_c = 0;
        rvalid = rready && (r_c >= r_dly);
        if (rvalid) rdata = rmem[ar_cap[5:2]];
        if (rready && !rvalid) r_c++; else if (!rready) r_c = 0;
      end
    end
  end

  // Monitor: handshakes, memory updates and valid-stability on each rising edge.
  initial begin
    logic        p_aw, p_w, p_ar;
    logic [31:0] pa_aw, pw_d, pa_ar;
    logic [3:0]  pw_s;
    logic [2:0]  pa_pr;
    p_aw = 0; p_w = 0; p_ar = 0; pa_aw = 0; pw_d = 0; pa_ar = 0; pw_s = 0; pa_pr = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        p_aw = 0; p_w = 0; p_ar = 0;
      end else begin
        if (p_aw && (!awvalid || awaddr !== pa_aw)) viol++;
        if (p_w && (!wvalid || wdata !== pw_d || wstrb !== pw_s)) viol++;
        if (p_ar && (!arvalid || araddr !== pa_ar || arprot !== pa_pr)) viol++;
        if (bready && (awvalid || wvalid)) viol++;
        if (awvalid && awprot !== 3'b000) viol++;
        if (awvalid && awready) begin aw_hs++; aw_t = cyc; aw_cap = awaddr; end
        if (wvalid && wready) begin w_hs++; w_t = cyc; wd_cap = wdata; ws_cap = wstrb; end
        if (bvalid && bready) begin
          b_hs++;
          for (int b = 0; b < 4; b++)
            if (ws_cap[b]) rmem[aw_cap[5:2]][8*b +: 8] = wd_cap[8*b +: 8];
        end
        if (arvalid && arready) begin ar_hs++; ar_cap = araddr; ap_cap = arprot; end
        if (rvalid && rready) r_hs++;
        p_aw = awvalid && !awready; pa_aw = awaddr;
        p_w  = wvalid && !wready;   pw_d = wdata; pw_s = wstrb;
        p_ar = arvalid && !arready; pa_ar = araddr; pa_pr = arprot;
      end
    end
  end

  task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic ins, input int exp_lat, input string tag,
                         output logic [31:0] rd);
    int n;
    n = 0;
    mem_valid = 1; mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = ins;
    do begin @(negedge clk); n++; end while (!mem_ready && n < 100);
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    rd = mem_rdata;
    mem_valid = 0; mem_wstrb = 0; mem_instr = 0;
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(mem_ready), 64'd0);
  endtask

  // Main directed sequence.
  initial begin
    logic [31:0] rd, last_rd, addr, wd;
    logic [31:0] model [16];
    logic [63:0] rng;
    logic [3:0]  strb, idx;
    logic        is_wr, ins;
    int          hs0, lat;

    reset = 1; mem_valid = 0; mem_instr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, mem_ready, busy, timeout}), 64'd0);
    chk("reset_rdata", 64'(mem_rdata), 64'd0);
    reset = 0;
    @(negedge clk);

    // Zero-wait read of 0x100, checked cycle by cycle.
    mem_valid = 1; mem_addr = 32'h100; mem_wstrb = 4'h0; mem_instr = 0;
    @(negedge clk);
    chk("rd_arvalid", 64'({arvalid, busy, awvalid}), 64'b110);
    chk("rd_araddr", 64'(araddr), 64'h100);
    chk("rd_arprot", 64'(arprot), 64'd0);
    @(negedge clk);
    chk("rd_rready", 64'({arvalid, rready, mem_ready}), 64'b010);
    @(negedge clk);
    chk("rd_ready", 64'(mem_ready), 64'd1);
    chk("rd_data", 64'(mem_rdata), 64'hCAFEF00D);
    mem_valid = 0;
    @(negedge clk);
    chk("rd_idle", 64'({mem_ready, busy}), 64'd0);
    chk("rd_ar_count", 64'(ar_hs), 64'd1);

    // Instruction fetch from 0x4.
    run_txn(32'h4, 32'h0, 4'h0, 1'b1, 3, "ifetch", rd);
    chk("ifetch_data", 64'(rd), 64'h11112222);
    chk("ifetch_prot", 64'(ap_cap), 64'b100);
    chk("ifetch_ar_count", 64'(ar_hs), 64'd2);

    // Write with W accepted three cycles after AW.
    aw_dly = 0; w_dly = 3; b_dly = 0;
    run_txn(32'h200, 32'h12345678, 4'b0101, 1'b0, 6, "wr_awfirst", rd);
    chk("wr_awfirst_order", 64'(w_t - aw_t), 64'd3);
    chk("wr_awfirst_addr", 64'(aw_cap), 64'h200);
    chk("wr_awfirst_wdata", 64'(wd_cap), 64'h12345678);
    chk("wr_awfirst_wstrb", 64'(ws_cap), 64'b0101);
    chk("wr_awfirst_rdata_kept", 64'(rd), 64'h11112222);
    chk("wr_awfirst_counts", 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h010101);
    chk("wr_awfirst_mem", 64'(rmem[0]), 64'hCA34F078);

    // Write with W accepted two cycles before AW.
    aw_dly = 2; w_dly = 0; b_dly = 0;
    run_txn(32'h204, 32'hA5A5A5A5, 4'hF, 1'b0, 5, "wr_wfirst", rd);
    chk("wr_wfirst_order", 64'(aw_t - w_t), 64'd2);
    chk("wr_wfirst_counts", 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h020202);

    // Write with AW and W in the same cycle and a slow B.
    aw_dly = 1; w_dly = 1; b_dly = 2;
    run_txn(32'h208, 32'hDEADBEEF, 4'b1000, 1'b0, 6, "wr_same", rd);
    chk("wr_same_order", 64'(aw_t), 64'(w_t));
    chk("wr_same_counts", 64'({8'(aw_hs), 8'(w_hs), 8'(b_hs)}), 64'h030303);

    // Read back the written words, one with responder waits.
    aw_dly = 0; w_dly = 0; b_dly = 0;
    run_txn(32'h200, 32'h0, 4'h0, 1'b0, 3, "rb0", rd);
    chk("rb0_data", 64'(rd), 64'hCA34F078);
    run_txn(32'h204, 32'h0, 4'h0, 1'b0, 3, "rb1", rd);
    chk("rb1_data", 64'(rd), 64'hA5A5A5A5);
    ar_dly = 2; r_dly = 1;
    run_txn(32'h208, 32'h0, 4'h0, 1'b0, 6, "rb2", rd);
    chk("rb2_data", 64'(rd), 64'hDE000000);
    last_rd = 32'hDE000000;

    // Randomised mixed traffic; the first 16 writes fill every word.
    rng = 64'h9E3779B97F4A7C15;
    for (int i = 0; i < 1000; i++) begin
      rng = xs64(rng);
      aw_dly = int'(rng[1:0]); w_dly = int'(rng[3:2]); b_dly = int'(rng[5:4]);
      ar_dly = int'(rng[7:6]); r_dly = int'(rng[9:8]);
      idx   = (i < 16) ? 4'(i) : rng[19:16];
      is_wr = (i < 16) || rng[20];
      strb  = (i < 16 || rng[27:24] == 4'h0) ? 4'hF : rng[27:24];
      ins   = rng[28];
      wd    = rng[63:32];
      addr  = 32'h1000 | {26'd0, idx, 2'b00};
      if (is_wr) begin
        lat = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
        run_txn(addr, wd, strb, 1'b0, lat, "rnd_wr", rd);
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        chk("rnd_wr_rdata_kept", 64'(rd), 64'(last_rd));
      end else begin
        lat = 3 + ar_dly + r_dly;
        run_txn(addr, 32'h0, 4'h0, ins, lat, "rnd_rd", rd);
        chk("rnd_rd_data", 64'(rd), 64'(model[idx]));
        chk("rnd_rd_prot", 64'(ap_cap), ins ? 64'b100 : 64'b000);
        last_rd = model[idx];
      end
    end
    chk("rnd_stability", 64'(viol), 64'd0);
    chk("rnd_timeout", 64'(timeout), 64'd0);

    // Stalled AR: watchdog fires after 16 cycles in RADDR, arvalid held.
    ar_dly = 100000; r_dly = 0;
    hs0 = ar_hs;
    mem_valid = 1; mem_addr = 32'h1008; mem_wstrb = 4'h0; mem_instr = 0;
    repeat (16) @(negedge clk);
    chk("wd_before", 64'({timeout, arvalid}), 64'b01);
    @(negedge clk);
    chk("wd_fired", 64'({timeout, arvalid, busy}), 64'b111);
    chk("wd_no_hs", 64'(ar_hs - hs0), 64'd0);
    #2 reset = 1;
    #1;
    chk("rst_async_ctrl", 64'({awvalid, wvalid, arvalid, bready, rready, mem_ready, busy, timeout}), 64'd0);
    chk("rst_async_rdata", 64'(mem_rdata), 64'd0);
    mem_valid = 0;
    @(negedge clk);
    reset = 0;
    ar_dly = 0;
    @(negedge clk);
    hs0 = ar_hs;
    run_txn(32'h1008, 32'h0, 4'h0, 1'b0, 3, "recover", rd);
    chk("recover_data", 64'(rd), 64'(model[2]));
    chk("recover_count", 64'(ar_hs - hs0), 64'd1);
    chk("recover_timeout", 64'(timeout), 64'd0);
    chk("final_stability", 64'(viol), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
